// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the pins, check each frame, decode
// make/break/extended prefixes and queue key events behind a ready/valid FIFO.
module ps2_rx_fifo #(
    parameter int unsigned FILT_LEN    = 3,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyClock,
    input  logic       keyData,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic [3:0] evt_digit,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    localparam int unsigned FiltW  = $clog2(FILT_LEN + 1);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = AddrW + 1;

    localparam logic [FiltW-1:0]  FiltLast  = FiltW'(FILT_LEN - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
    localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRecv, StStop} stateT;

    // ------------------------------------------------------------------
    // Pin synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0]       clkSync;
    logic [1:0]       dataSync;
    logic             filtLvl;
    logic [FiltW-1:0] filtCnt;
    logic             strobe;
    logic             dataBit;

    assign dataBit = dataSync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], keyClock};
            dataSync <= {dataSync[0], keyData};
        end
    end

    // The filtered level flips on the FILT_LEN-th consecutive differing sample;
    // strobe marks the 1->0 flip for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filtLvl <= 1'b1;
            filtCnt <= '0;
            strobe  <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clkSync[1] == filtLvl) begin
                filtCnt <= '0;
            end else if (filtCnt == FiltLast) begin
                filtLvl <= clkSync[1];
                filtCnt <= '0;
                strobe  <= filtLvl;
            end else begin
                filtCnt <= filtCnt + FiltW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    stateT             stateQ, stateD;
    logic [3:0]        bitCntQ, bitCntD;
    logic [8:0]        shiftQ, shiftD;
    logic [TimerW-1:0] timerQ, timerD;
    logic              acceptQ, acceptD;
    logic              parErrD, frmErrD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ      <= StIdle;
            bitCntQ     <= '0;
            shiftQ      <= '0;
            timerQ      <= '0;
            acceptQ     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            stateQ      <= stateD;
            bitCntQ     <= bitCntD;
            shiftQ      <= shiftD;
            timerQ      <= timerD;
            acceptQ     <= acceptD;
            parity_err  <= parErrD;
            framing_err <= frmErrD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        timerD  = timerQ;
        acceptD = 1'b0;
        parErrD = 1'b0;
        frmErrD = 1'b0;
        case (stateQ)
            StIdle: begin
                timerD = '0;
                if (strobe && !dataBit) begin
                    stateD  = StRecv;
                    bitCntD = '0;
                end
            end
            StRecv: begin
                if (strobe) begin
                    timerD = '0;
                    // Data LSB first, parity last: after 9 shifts parity sits in bit 8.
                    shiftD = {dataBit, shiftQ[8:1]};
                    if (bitCntQ == 4'd8) begin
                        stateD = StStop;
                    end else begin
                        bitCntD = bitCntQ + 4'd1;
                    end
                end else if (timerQ == TimerLast) begin
                    frmErrD = 1'b1;
                    stateD  = StIdle;
                end else begin
                    timerD = timerQ + TimerW'(1);
                end
            end
            StStop: begin
                if (strobe) begin
                    timerD = '0;
                    stateD = StIdle;
                    if (!dataBit) begin
                        frmErrD = 1'b1;
                    end else if (!(^shiftQ)) begin
                        parErrD = 1'b1;
                    end else begin
                        acceptD = 1'b1;
                    end
                end else if (timerQ == TimerLast) begin
                    frmErrD = 1'b1;
                    stateD  = StIdle;
                end else begin
                    timerD = timerQ + TimerW'(1);
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Prefix decoder and digit translation
    // ------------------------------------------------------------------
    logic [7:0] rxByte;
    logic       extPend, brkPend;
    logic       isPrefix;
    logic       pushReq;
    logic [3:0] digit;

    assign rxByte   = shiftQ[7:0];
    assign isPrefix = (rxByte == 8'hE0) || (rxByte == 8'hF0);
    assign pushReq  = acceptQ && !isPrefix;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            extPend <= 1'b0;
            brkPend <= 1'b0;
        end else if (parity_err || framing_err) begin
            extPend <= 1'b0;
            brkPend <= 1'b0;
        end else if (acceptQ) begin
            if (rxByte == 8'hE0) begin
                extPend <= 1'b1;
            end else if (rxByte == 8'hF0) begin
                brkPend <= 1'b1;
            end else begin
                extPend <= 1'b0;
                brkPend <= 1'b0;
            end
        end
    end

    always_comb begin
        digit = 4'hF;
        if (!extPend) begin
            case (rxByte)
                8'h45:   digit = 4'd0;
                8'h16:   digit = 4'd1;
                8'h1E:   digit = 4'd2;
                8'h26:   digit = 4'd3;
                8'h25:   digit = 4'd4;
                8'h2E:   digit = 4'd5;
                8'h36:   digit = 4'd6;
                8'h3D:   digit = 4'd7;
                8'h3E:   digit = 4'd8;
                8'h46:   digit = 4'd9;
                default: digit = 4'hF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [13:0]       mem [FIFO_DEPTH];
    logic [AddrW-1:0]  wrPtr, rdPtr;
    logic [CountW-1:0] count;
    logic              full, pop, doPush;
    logic [13:0]       headWord;

    assign full      = (count == CountFull);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign doPush    = pushReq && (!full || pop);
    assign headWord  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= {rxByte, brkPend, extPend, digit};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AddrW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AddrW'(1);
            end
            if (doPush && !pop) begin
                count <= count + CountW'(1);
            end else if (pop && !doPush) begin
                count <= count - CountW'(1);
            end
            if (pushReq && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head fields read as their reset values while the FIFO is empty.
    assign evt_code  = evt_valid ? headWord[13:6] : 8'h00;
    assign evt_break = evt_valid ? headWord[5] : 1'b0;
    assign evt_ext   = evt_valid ? headWord[4] : 1'b0;
    assign evt_digit = evt_valid ? headWord[3:0] : 4'hF;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames on the pins and checks decoded events,
// error pulses and FIFO flow control against hand-computed values.
module tb_ps2_rx_fifo;

    localparam int unsigned FILT_LEN    = 3;
    localparam int unsigned TIMEOUT_CYC = 200;
    localparam int unsigned FIFO_DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       keyClock;
    logic       keyData;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic [3:0] evt_digit;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int nChecks = 0;
    int nErrs   = 0;
    int parCnt  = 0;
    int frmCnt  = 0;
    logic [13:0] evQ[$];

    ps2_rx_fifo #(
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keyClock   (keyClock),
        .keyData    (keyData),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_break  (evt_break),
        .evt_ext    (evt_ext),
        .evt_digit  (evt_digit),
        .parity_err (parity_err),
        .framing_err(framing_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Record accepted events and error-pulse cycles away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (evt_valid && evt_ready) evQ.push_back({evt_code, evt_break, evt_ext, evt_digit});
            if (parity_err) parCnt++;
            if (framing_err) frmCnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        keyData = b;
        tick(10);
        keyClock = 1'b0;
        tick(20);
        keyClock = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flipPar, input logic badStop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flipPar);
        send_bit(!badStop);
        keyData = 1'b1;
        tick(20);
    endtask

    task automatic test_reset;
        reset = 1'b0; keyClock = 1'b1; keyData = 1'b1; evt_ready = 1'b0;
        tick(3);
        nChecks++; if (evt_valid !== 1'b0) begin nErrs++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        nChecks++; if (evt_code !== 8'h00) begin nErrs++; $display("FAIL reset_code got %h want 00", evt_code); end
        nChecks++; if (evt_break !== 1'b0) begin nErrs++; $display("FAIL reset_break got %b want 0", evt_break); end
        nChecks++; if (evt_ext !== 1'b0) begin nErrs++; $display("FAIL reset_ext got %b want 0", evt_ext); end
        nChecks++; if (evt_digit !== 4'hF) begin nErrs++; $display("FAIL reset_digit got %h want f", evt_digit); end
        nChecks++; if (parity_err !== 1'b0) begin nErrs++; $display("FAIL reset_perr got %b want 0", parity_err); end
        nChecks++; if (framing_err !== 1'b0) begin nErrs++; $display("FAIL reset_ferr got %b want 0", framing_err); end
        nChecks++; if (overflow !== 1'b0) begin nErrs++; $display("FAIL reset_ovf got %b want 0", overflow); end
        reset = 1'b1;
        tick(5);
    endtask

    task automatic test_clean_frame;
        int base = evQ.size();
        int p0 = parCnt;
        int f0 = frmCnt;
        evt_ready = 1'b1;
        send_frame(8'h16, 1'b0, 1'b0);
        nChecks++; if (evQ.size() - base !== 1) begin nErrs++; $display("FAIL clean_count got %0d want 1", evQ.size() - base); end
        else begin
            nChecks++; if (evQ[base] !== {8'h16, 1'b0, 1'b0, 4'h1}) begin nErrs++; $display("FAIL clean_evt got %h want %h", evQ[base], {8'h16, 1'b0, 1'b0, 4'h1}); end
        end
        nChecks++; if (parCnt - p0 !== 0 || frmCnt - f0 !== 0) begin nErrs++; $display("FAIL clean_errs got p=%0d f=%0d want 0 0", parCnt - p0, frmCnt - f0); end
    endtask

    task automatic test_break_ext;
        int base = evQ.size();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h45, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h45, 1'b0, 1'b0);
        nChecks++; if (evQ.size() - base !== 3) begin nErrs++; $display("FAIL brkext_count got %0d want 3", evQ.size() - base); end
        else begin
            nChecks++; if (evQ[base] !== {8'h45, 1'b1, 1'b0, 4'h0}) begin nErrs++; $display("FAIL break_evt got %h want %h", evQ[base], {8'h45, 1'b1, 1'b0, 4'h0}); end
            nChecks++; if (evQ[base+1] !== {8'h75, 1'b0, 1'b1, 4'hF}) begin nErrs++; $display("FAIL ext_evt got %h want %h", evQ[base+1], {8'h75, 1'b0, 1'b1, 4'hF}); end
            nChecks++; if (evQ[base+2] !== {8'h45, 1'b0, 1'b1, 4'hF}) begin nErrs++; $display("FAIL ext_digit got %h want %h", evQ[base+2], {8'h45, 1'b0, 1'b1, 4'hF}); end
        end
    endtask

    task automatic test_parity;
        int base = evQ.size();
        int p0 = parCnt;
        int f0 = frmCnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h26, 1'b1, 1'b0);
        nChecks++; if (parCnt - p0 !== 1) begin nErrs++; $display("FAIL par_pulse got %0d want 1", parCnt - p0); end
        nChecks++; if (frmCnt - f0 !== 0) begin nErrs++; $display("FAIL par_ferr got %0d want 0", frmCnt - f0); end
        nChecks++; if (evQ.size() - base !== 0) begin nErrs++; $display("FAIL par_noevt got %0d want 0", evQ.size() - base); end
        // The error also dropped the pending F0, so this is a plain make code.
        send_frame(8'h25, 1'b0, 1'b0);
        nChecks++; if (evQ.size() - base !== 1) begin nErrs++; $display("FAIL par_next_count got %0d want 1", evQ.size() - base); end
        else begin
            nChecks++; if (evQ[base] !== {8'h25, 1'b0, 1'b0, 4'h4}) begin nErrs++; $display("FAIL par_next_evt got %h want %h", evQ[base], {8'h25, 1'b0, 1'b0, 4'h4}); end
        end
    endtask

    task automatic test_stop_err;
        int base = evQ.size();
        int p0 = parCnt;
        int f0 = frmCnt;
        send_frame(8'h46, 1'b0, 1'b1);
        send_frame(8'h46, 1'b1, 1'b1);
        nChecks++; if (frmCnt - f0 !== 2) begin nErrs++; $display("FAIL stop_ferr got %0d want 2", frmCnt - f0); end
        nChecks++; if (parCnt - p0 !== 0) begin nErrs++; $display("FAIL stop_perr got %0d want 0", parCnt - p0); end
        nChecks++; if (evQ.size() - base !== 0) begin nErrs++; $display("FAIL stop_noevt got %0d want 0", evQ.size() - base); end
    endtask

    task automatic test_timeout;
        int base = evQ.size();
        int f0 = frmCnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        keyData = 1'b1;
        tick(TIMEOUT_CYC + 10);
        nChecks++; if (frmCnt - f0 !== 1) begin nErrs++; $display("FAIL tmo_pulse got %0d want 1", frmCnt - f0); end
        nChecks++; if (evQ.size() - base !== 0) begin nErrs++; $display("FAIL tmo_noevt got %0d want 0", evQ.size() - base); end
        send_frame(8'h3D, 1'b0, 1'b0);
        nChecks++; if (evQ.size() - base !== 1) begin nErrs++; $display("FAIL tmo_next_count got %0d want 1", evQ.size() - base); end
        else begin
            nChecks++; if (evQ[base] !== {8'h3D, 1'b0, 1'b0, 4'h7}) begin nErrs++; $display("FAIL tmo_next_evt got %h want %h", evQ[base], {8'h3D, 1'b0, 1'b0, 4'h7}); end
        end
    endtask

    task automatic test_glitch;
        int base = evQ.size();
        int p0 = parCnt;
        int f0 = frmCnt;
        // A real strobe here with data low would start a bogus frame.
        keyData = 1'b0;
        tick(5);
        keyClock = 1'b0;
        tick(FILT_LEN - 1);
        keyClock = 1'b1;
        tick(10);
        keyData = 1'b1;
        tick(20);
        send_frame(8'h1E, 1'b0, 1'b0);
        nChecks++; if (evQ.size() - base !== 1) begin nErrs++; $display("FAIL glitch_count got %0d want 1", evQ.size() - base); end
        else begin
            nChecks++; if (evQ[base] !== {8'h1E, 1'b0, 1'b0, 4'h2}) begin nErrs++; $display("FAIL glitch_evt got %h want %h", evQ[base], {8'h1E, 1'b0, 1'b0, 4'h2}); end
        end
        nChecks++; if (parCnt - p0 !== 0 || frmCnt - f0 !== 0) begin nErrs++; $display("FAIL glitch_errs got p=%0d f=%0d want 0 0", parCnt - p0, frmCnt - f0); end
    endtask

    task automatic test_overflow;
        evt_ready = 1'b0;
        send_frame(8'h16, 1'b0, 1'b0);
        send_frame(8'h1E, 1'b0, 1'b0);
        send_frame(8'h26, 1'b0, 1'b0);
        send_frame(8'h25, 1'b0, 1'b0);
        nChecks++; if (evt_valid !== 1'b1) begin nErrs++; $display("FAIL ovf_valid got %b want 1", evt_valid); end
        nChecks++; if (overflow !== 1'b0) begin nErrs++; $display("FAIL ovf_early got %b want 0", overflow); end
        nChecks++; if (evt_code !== 8'h16) begin nErrs++; $display("FAIL ovf_head got %h want 16", evt_code); end
        send_frame(8'h2E, 1'b0, 1'b0);
        nChecks++; if (overflow !== 1'b1) begin nErrs++; $display("FAIL ovf_set got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back;
        int base = evQ.size();
        logic [7:0] codes [4];
        logic [3:0] digs [4];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25};
        digs  = '{4'h1, 4'h2, 4'h3, 4'h4};
        evt_ready = 1'b1;
        tick(FIFO_DEPTH);
        nChecks++; if (evt_valid !== 1'b0) begin nErrs++; $display("FAIL b2b_empty got %b want 0", evt_valid); end
        nChecks++; if (evQ.size() - base !== FIFO_DEPTH) begin nErrs++; $display("FAIL b2b_count got %0d want %0d", evQ.size() - base, FIFO_DEPTH); end
        else begin
            for (int i = 0; i < 4; i++) begin
                nChecks++;
                if (evQ[base+i] !== {codes[i], 1'b0, 1'b0, digs[i]}) begin
                    nErrs++; $display("FAIL b2b_evt%0d got %h want %h", i, evQ[base+i], {codes[i], 1'b0, 1'b0, digs[i]});
                end
            end
        end
        nChecks++; if (overflow !== 1'b1) begin nErrs++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        reset = 1'b0;
        tick(1);
        nChecks++; if (overflow !== 1'b0) begin nErrs++; $display("FAIL ovf_reset got %b want 0", overflow); end
        reset = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_break_ext();
        test_parity();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_overflow();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver with glitch filtering, full frame checking (start, odd parity, stop, inter-bit timeout), make/break and extended-prefix decoding, and an event FIFO with a ready/valid output. It sits between the board PS/2 pins and the display/control logic. It replaces free-running scan-code latching with lossless, flow-controlled key events that carry a 0–9 digit translation.

## Interface
- FILT_LEN, 3: consecutive equal synchronised samples required before the filtered keyClock level changes (≥1).
- TIMEOUT_CYC, 50000: clk cycles without a falling edge that abort a frame in progress (≥2).
- FIFO_DEPTH, 8: event FIFO entries, power of two ≥2.

- clk  in  1  system clock, rising edge only
- reset  in  1  asynchronous, active-low reset
- keyClock  in  1  PS/2 clock pin, asynchronous
- keyData  in  1  PS/2 data pin, asynchronous
- evt_valid  out  1  FIFO head valid (FIFO not empty)
- evt_ready  in  1  consumer accepts head
- evt_code  out  8  scan code of head event
- evt_break  out  1  head event was preceded by F0 (key release)
- evt_ext  out  1  head event was preceded by E0
- evt_digit  out  4  0–9 translation of head event; 4'hF if not a digit
- parity_err  out  1  one-cycle pulse, bad parity
- framing_err  out  1  one-cycle pulse, bad stop bit or timeout
- overflow  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- keyClock and keyData each pass through a 2-flop synchroniser. Filtered clock level starts at 1 and changes only after FILT_LEN consecutive synchronised samples hold the new value.
- Strobe: one-cycle pulse when the filtered clock goes 1→0. The synchronised keyData is sampled on the strobe cycle.
- Frame FSM:
  - IDLE: strobe with data 0 → RECV, bit count 0. Strobe with data 1 is ignored.
  - RECV: 8 data bits LSB first, then the parity bit (9 strobes) → STOP.
  - STOP: on strobe, the byte is accepted only if data=1 and the 9 bits contain an odd number of ones. Bad parity pulses parity_err. Stop=0 pulses framing_err. If both are bad, only framing_err pulses. Always → IDLE.
- Timeout counter clears on every strobe and in IDLE. If it reaches TIMEOUT_CYC in RECV or STOP: framing_err pulse, partial byte discarded, → IDLE.
- Decoder, for each accepted byte:
  - E0 sets ext_pend. F0 sets brk_pend. Neither produces an event.
  - Any other byte, including E1, pushes {code, brk_pend, ext_pend, digit}, then both pend flags clear.
  - Any error pulse also clears both pend flags.
- Digit map, applied only when ext_pend=0: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9. Everything else → F. Break events are translated the same way.
- FIFO:
  - Push when full and no pop in the same cycle: event dropped, overflow←1, held until reset.
  - Push and pop in the same cycle while full: both happen, count unchanged.
  - Pop when empty: impossible, since evt_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Head outputs show the FIFO head whenever evt_valid=1. Their values are don't-care otherwise.

## Timing
- Reset values: evt_valid 0, evt_code 0, evt_break 0, evt_ext 0, evt_digit F, parity_err 0, framing_err 0, overflow 0. FSM in IDLE, FIFO empty, pend flags 0, filtered clock 1.
- Reset mid-frame or with a non-empty FIFO: all state is discarded, with no error pulse.
- Strobe latency: 2+FILT_LEN clk cycles after a clean pin falling edge.
- Event latency: with the FIFO empty, evt_valid rises 2 cycles after the STOP strobe cycle (cycle N: byte accepted; N+1: FIFO write; N+2: evt_valid=1).
- Error pulses are asserted in cycle N+1 for one cycle.
- Handshake: a pop occurs on a rising clk with evt_valid=1 and evt_ready=1. The next head appears in the following cycle. evt_valid may stay high back-to-back.
- Throughput: one event per clk. A PS/2 frame is far slower.

## Test plan
- Clean frame 0x16 (start 0, data LSB first, parity 0, stop 1), evt_ready=1 → one event: code 16, break 0, ext 0, digit 1. No error pulses.
- Sequence F0, 45 → one event: code 45, break 1, digit 0. Then E0, 75 → code 75, ext 1, digit F.
- Frame 0x26 with its parity bit inverted → parity_err pulses once, no event. The next clean frame 0x25 yields digit 4.
- 5 bits sent, then the line goes idle for TIMEOUT_CYC+10 cycles → framing_err pulses once, FSM returns to IDLE, no event. A following clean frame is decoded correctly.
- keyClock glitch low for FILT_LEN-1 cycles during the IDLE high period → no strobe, no state change.
- evt_ready=0 while sending FIFO_DEPTH+1 digit frames → FIFO_DEPTH events are held, overflow=1. Draining returns them in order, and the last frame is lost.
